rv32i_mem_bridge: RTL and testbench

//  Memory-side responder for rv32i load/store/fetch requests. Accepts one request at a time and splits it into
//  16-bit transactions on a halfword-wide memory port: one for byte/half, two (low then high) for word.

---
 rtl/rv32i_mem_bridge_if.sv | 47 ++++
 rtl/rv32i_mem_bridge.sv | 140 ++++++++++++++
 tb/tb_rv32i_mem_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_bridge_if.sv
// Bus interfaces around the rv32i memory bridge: core-side request/response
// channel and the 16-bit halfword memory port.
interface rv32i_req_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_write_i;
  logic [XLEN-1:0] req_addr_i;
  logic [2:0]      req_size_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_rdata_o;
  logic            resp_error_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o
  );
endinterface

interface rv32i_mem_if #(
  parameter int ADDR_BITS = 16
);
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic [15:0]          mem_wdata_o;
  logic [1:0]           mem_wmask_o;
  logic [15:0]          mem_rdata_i;
  logic                 mem_ack_i;

  modport master (
    output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/rv32i_mem_bridge.sv
// Splits one rv32i load/store into one or two 16-bit memory transactions, with
// lane steering, masking, load extension, misalignment and ack-timeout checks.
module rv32i_mem_bridge #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  rv32i_req_if.slave  req,
  rv32i_mem_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state_q;
  logic             write_q;
  logic [ADDR_BITS:0] addr_q;
  logic [2:0]       size_q;
  logic [XLEN-1:0]  wdata_q;
  logic [15:0]      lo_q;
  logic [15:0]      hi_q;
  logic [CW-1:0]    cnt_q;

  logic             req_bad;
  logic             is_word;
  logic             hi_phase;
  logic             busy;
  logic [7:0]       load_byte;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^req.req_addr_i[XLEN-1:ADDR_BITS+1];
  assign is_word  = (size_q[1:0] == 2'b10);
  assign hi_phase = (state_q == S_HI);
  assign busy     = (state_q == S_LO) || hi_phase;

  // Illegal funct3 codes, unsigned stores and misaligned H/W are rejected up front.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_bad = 1'b1;
    case (req.req_size_i)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req.req_addr_i[0];
      3'b010:  req_bad = (req.req_addr_i[1:0] != 2'b00);
      3'b100:  req_bad = req.req_write_i;
      3'b101:  req_bad = req.req_write_i | req.req_addr_i[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req.req_valid_i) begin
            write_q <= req.req_write_i;
            addr_q  <= req.req_addr_i[ADDR_BITS:0];
            size_q  <= req.req_size_i;
            wdata_q <= req.req_wdata_i;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            state_q <= req_bad ? S_ERR : S_LO;
          end
        end
        S_LO, S_HI: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (mem.mem_ack_i) begin
            cnt_q <= '0;
            if (hi_phase) begin
              if (!write_q) hi_q <= mem.mem_rdata_i;
              state_q <= S_RESP;
            end else begin
              if (!write_q) lo_q <= mem.mem_rdata_i;
              state_q <= is_word ? S_HI : S_RESP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(TIMEOUT - 1)) state_q <= S_ERR;
          end
        end
        S_RESP, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

  // Memory port is driven only while a transaction is outstanding, zero otherwise.
  always_comb begin
    mem.mem_read_o  = 1'b0;
    mem.mem_write_o = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    mem.mem_wmask_o = '0;
    if (busy) begin
      mem.mem_read_o  = !write_q;
      mem.mem_write_o = write_q;
      mem.mem_addr_o  = addr_q[ADDR_BITS:1] + {{(ADDR_BITS-1){1'b0}}, hi_phase};
      if (size_q[1:0] == 2'b00) begin
        mem.mem_wmask_o = addr_q[0] ? 2'b10 : 2'b01;
        mem.mem_wdata_o = {wdata_q[7:0], wdata_q[7:0]};
      end else begin
        mem.mem_wmask_o = 2'b11;
        mem.mem_wdata_o = hi_phase ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  always_comb begin
    req.req_ready_o  = (state_q == S_IDLE);
    req.resp_valid_o = (state_q == S_RESP) || (state_q == S_ERR);
    req.resp_error_o = (state_q == S_ERR);
    req.resp_rdata_o = '0;
    load_byte        = addr_q[0] ? lo_q[15:8] : lo_q[7:0];
    if ((state_q == S_RESP) && !write_q) begin
      case (size_q[1:0])
        2'b00:   req.resp_rdata_o = {{(XLEN-8){!size_q[2] & load_byte[7]}}, load_byte};
        2'b01:   req.resp_rdata_o = {{(XLEN-16){!size_q[2] & lo_q[15]}}, lo_q};
        default: req.resp_rdata_o = XLEN'({hi_q, lo_q});
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_bridge.sv
// Self-checking bench for rv32i_mem_bridge: directed cases plus random requests
// against a byte-addressed reference memory and a halfword memory responder.
module tb_rv32i_mem_bridge;

  localparam int TIMEOUT = 20;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
  } tx_t;

  logic clk_i = 1'b0;
  logic reset_i;

  rv32i_req_if #(.XLEN(32))      rif ();
  rv32i_mem_if #(.ADDR_BITS(16)) mif ();

  rv32i_mem_bridge #(.XLEN(32), .ADDR_BITS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req     (rif),
    .mem     (mif)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem16 [0:65535];
  logic [7:0]  ref_b [0:131071];
  tx_t         txq[$];
  int          unstable_cnt = 0;
  int          ack_delay = 0;
  bit          ack_never = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after ack_delay waiting cycles, logs each completed transaction.
  int          wait_cnt = 0;
  bit          held = 0;
  logic [15:0] last_addr, last_wdata;
  logic [1:0]  last_mask;
  logic        last_rd, last_wr;

  always @(negedge clk_i) begin
    if (reset_i === 1'b1 || !(mif.mem_read_o === 1'b1 || mif.mem_write_o === 1'b1)) begin
      mif.mem_ack_i   = 1'b0;
      mif.mem_rdata_i = 16'h0;
      wait_cnt        = 0;
      held            = 0;
    end else begin
      if (held && (mif.mem_addr_o !== last_addr || mif.mem_wdata_o !== last_wdata ||
                   mif.mem_wmask_o !== last_mask || mif.mem_read_o !== last_rd ||
                   mif.mem_write_o !== last_wr))
        unstable_cnt++;
      if (!ack_never && wait_cnt == ack_delay) begin
        mif.mem_ack_i   = 1'b1;
        mif.mem_rdata_i = mem16[mif.mem_addr_o];
        if (mif.mem_write_o) begin
          if (mif.mem_wmask_o[0]) mem16[mif.mem_addr_o][7:0]  = mif.mem_wdata_o[7:0];
          if (mif.mem_wmask_o[1]) mem16[mif.mem_addr_o][15:8] = mif.mem_wdata_o[15:8];
        end
        txq.push_back('{mif.mem_write_o, mif.mem_addr_o, mif.mem_wdata_o, mif.mem_wmask_o});
        wait_cnt = 0;
        held     = 0;
      end else begin
        mif.mem_ack_i = 1'b0;
        wait_cnt++;
        held       = 1;
        last_addr  = mif.mem_addr_o;
        last_wdata = mif.mem_wdata_o;
        last_mask  = mif.mem_wmask_o;
        last_rd    = mif.mem_read_o;
        last_wr    = mif.mem_write_o;
      end
    end
  end

  task automatic do_req(input string name, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input int dly, input bit never);
    int          nb, ntx, exp_lat, lat, base, ubase;
    bit          legal, exp_err;
    longint      v;
    logic [31:0] exp_rd;
    logic [15:0] exp_addr, exp_wdata;
    logic [1:0]  exp_mask;
    tx_t         t;
    nb      = 1 << sz[1:0];
    legal   = (sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(wr && sz[2]) &&
              ((a & 32'(nb - 1)) == 0);
    exp_err = !legal || never;
    ntx     = exp_err ? 0 : (nb == 4 ? 2 : 1);
    exp_lat = !legal ? 1 : (never ? TIMEOUT + 1 : ntx * (dly + 1) + 1);
    exp_rd  = 32'h0;
    if (!exp_err && !wr) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_b[(a + 32'(i)) & 32'h1FFFF]) << (8 * i));
      if (!sz[2] && nb < 4 && v[8 * nb - 1]) v = v - (64'sd1 <<< (8 * nb));
      exp_rd = v[31:0];
    end

    ack_delay = dly;
    ack_never = never;
    base      = txq.size();
    ubase     = unstable_cnt;
    @(negedge clk_i);
    check({name, ":ready"}, 32'(rif.req_ready_o), 32'd1);
    rif.req_write_i = wr;
    rif.req_addr_i  = a;
    rif.req_size_i  = sz;
    rif.req_wdata_i = wd;
    rif.req_valid_i = 1'b1;
    @(negedge clk_i);
    rif.req_valid_i = 1'b0;
    lat = 1;
    check({name, ":busy"}, 32'(rif.req_ready_o), 32'd0);
    while (rif.resp_valid_o !== 1'b1 && lat < 2 * TIMEOUT + 20) begin
      @(negedge clk_i);
      lat++;
    end
    check({name, ":resp_valid"}, 32'(rif.resp_valid_o), 32'd1);
    check({name, ":latency"}, 32'(lat), 32'(exp_lat));
    check({name, ":error"}, 32'(rif.resp_error_o), 32'(exp_err));
    check({name, ":rdata"}, rif.resp_rdata_o, exp_rd);
    check({name, ":ntx"}, 32'(txq.size() - base), 32'(ntx));
    check({name, ":stable"}, 32'(unstable_cnt - ubase), 32'd0);
    for (int k = 0; k < ntx && base + k < txq.size(); k++) begin
      t        = txq[base + k];
      exp_addr = a[16:1] + 16'(k);
      check({name, ":tx_addr"}, 32'(t.addr), 32'(exp_addr));
      check({name, ":tx_dir"}, 32'(t.wr), 32'(wr));
      if (wr) begin
        exp_mask  = (nb == 1) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        exp_wdata = (nb == 1) ? {wd[7:0], wd[7:0]} : (k == 1 ? wd[31:16] : wd[15:0]);
        check({name, ":tx_mask"}, 32'(t.mask), 32'(exp_mask));
        check({name, ":tx_wdata"}, 32'(t.wdata), 32'(exp_wdata));
      end
    end
    @(negedge clk_i);
    check({name, ":pulse_end"}, 32'(rif.resp_valid_o), 32'd0);
    check({name, ":strobes_low"}, 32'({mif.mem_read_o, mif.mem_write_o}), 32'd0);
    if (!exp_err && wr)
      for (int i = 0; i < nb; i++) ref_b[(a + 32'(i)) & 32'h1FFFF] = wd[8 * i +: 8];
  endtask

  initial begin
    int          n;
    logic [31:0] ra;
    bit          seen;
    reset_i         = 1'b1;
    rif.req_valid_i = 1'b0;
    rif.req_write_i = 1'b0;
    rif.req_addr_i  = '0;
    rif.req_size_i  = '0;
    rif.req_wdata_i = '0;
    for (int i = 0; i < 65536; i++) begin
      mem16[i]         = 16'($urandom);
      ref_b[2 * i]     = mem16[i][7:0];
      ref_b[2 * i + 1] = mem16[i][15:8];
    end
    mem16[0] = 16'h80FF;
    ref_b[0] = 8'hFF;
    ref_b[1] = 8'h80;

    repeat (2) @(negedge clk_i);
    check("rst:ready", 32'(rif.req_ready_o), 32'd1);
    check("rst:resp", 32'({rif.resp_valid_o, rif.resp_error_o}), 32'd0);
    check("rst:strobes", 32'({mif.mem_read_o, mif.mem_write_o}), 32'd0);
    check("rst:addr", 32'(mif.mem_addr_o), 32'd0);
    check("rst:wdata_mask", 32'({mif.mem_wdata_o, mif.mem_wmask_o}), 32'd0);
    check("rst:rdata", rif.resp_rdata_o, 32'd0);
    reset_i = 1'b0;

    do_req("lb",      1'b0, 32'h0000_0001, 3'b000, 32'h0, 0, 0);
    do_req("lbu",     1'b0, 32'h0000_0001, 3'b100, 32'h0, 0, 0);
    do_req("sw",      1'b1, 32'h0000_0004, 3'b010, 32'hDEAD_BEEF, 0, 0);
    do_req("lw_back", 1'b0, 32'h0000_0004, 3'b010, 32'h0, 1, 0);
    do_req("sb",      1'b1, 32'h0000_0003, 3'b000, 32'h0000_00A5, 0, 0);
    do_req("lh_mis",  1'b0, 32'h0000_0003, 3'b001, 32'h0, 0, 0);
    do_req("sbu_ill", 1'b1, 32'h0000_0008, 3'b100, 32'h1234_5678, 0, 0);
    do_req("size_ill",1'b0, 32'h0000_0008, 3'b011, 32'h0, 0, 0);
    do_req("lw_wrap", 1'b0, 32'h0001_FFFE, 3'b010, 32'h0, 3, 0);
    do_req("lhu",     1'b0, 32'h0000_0002, 3'b101, 32'h0, 2, 0);
    do_req("timeout", 1'b0, 32'h0000_0010, 3'b001, 32'h0, 0, 1);
    do_req("ack_last",1'b0, 32'h0000_0011, 3'b000, 32'h0, TIMEOUT - 1, 0);

    // Reset while the upper half of a word load is waiting for its ack.
    ack_delay = 4;
    ack_never = 0;
    n = 0;
    @(negedge clk_i);
    rif.req_write_i = 1'b0;
    rif.req_addr_i  = 32'h0000_0040;
    rif.req_size_i  = 3'b010;
    rif.req_valid_i = 1'b1;
    @(negedge clk_i);
    rif.req_valid_i = 1'b0;
    while (!(mif.mem_read_o === 1'b1 && mif.mem_addr_o === 16'h0021) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_hi:reached", 32'(mif.mem_addr_o), 32'h21);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("rst_hi:strobes", 32'({mif.mem_read_o, mif.mem_write_o}), 32'd0);
    check("rst_hi:resp", 32'(rif.resp_valid_o), 32'd0);
    check("rst_hi:ready", 32'(rif.req_ready_o), 32'd1);
    reset_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk_i);
      seen |= (rif.resp_valid_o === 1'b1);
    end
    check("rst_hi:no_resp", 32'(seen), 32'd0);
    do_req("rst_hi:fresh", 1'b0, 32'h0000_0040, 3'b010, 32'h0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 1) ? 32'h0000_0200 : 32'h0001_FFF0) + 32'($urandom_range(0, 15));
      ra = ra | ($urandom & 32'hFFFE_0000);
      do_req("rand", 1'($urandom_range(0, 1)), ra, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
